// File: rtl/jk_step_driver.sv
// jk_step_driver
//
// Stimulus front-end for the lab JK flip-flop stage. Raw switches and the step
// button are synchronized and debounced. Each accepted trigger produces one
// clean flip-flop clock pulse, with J/K held steady around it.
//
// Parameters
//   DB_CYCLES  consecutive differing cycles before a debounced input follows (>= 2)
//   DIV        auto-mode tick period in CLK cycles (>= 8)
//
// Ports
//   CLK       system clock, rising edge
//   RST_n     synchronous active-low reset
//   SW_J      raw J switch (async, bouncy)
//   SW_K      raw K switch (async, bouncy)
//   BTN_STEP  raw step pushbutton, active-high (async, bouncy)
//   MODE      0 = manual (one step per press), 1 = auto (pattern on divided tick)
//   J_OUT     J level to flip-flop
//   K_OUT     K level to flip-flop
//   FF_CLK    flip-flop clock pulse, 2 cycles high per step
//   BUSY      step sequence in progress
//   STEP_CNT  FF_CLK pulses issued, wraps at 256
module jk_step_driver #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned DIV       = 50000
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       SW_J,
  input  logic       SW_K,
  input  logic       BTN_STEP,
  input  logic       MODE,
  output logic       J_OUT,
  output logic       K_OUT,
  output logic       FF_CLK,
  output logic       BUSY,
  output logic [7:0] STEP_CNT
);

  localparam int unsigned DbW  = $clog2(DB_CYCLES + 1);
  localparam int unsigned DivW = $clog2(DIV);

  localparam logic [DbW-1:0]  DbLast  = DbW'(DB_CYCLES - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  // Auto phases: SET(1,0) -> TOGGLE(1,1) -> RESET(0,1) -> HOLD(0,0)
  localparam logic [1:0] PhaseSet = 2'd0;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh1,
    StHigh2,
    StHold
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizers: bit 0 = J, 1 = K, 2 = button, 3 = mode
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q, sync2_q;
  logic       mode_s;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {MODE, BTN_STEP, SW_K, SW_J};
      sync2_q <= sync1_q;
    end
  end

  assign mode_s = sync2_q[3];

  // ---------------------------------------------------------------------------
  // Debouncers for J, K and button
  // ---------------------------------------------------------------------------
  logic [2:0]     deb_q, deb_d;
  logic [DbW-1:0] db_cnt_q [3];
  logic [DbW-1:0] db_cnt_d [3];

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        // Flip on the cycle the count would reach DB_CYCLES
        if (db_cnt_q[i] == DbLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      deb_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Button edge detector (registered pulse) and mode change detector
  // ---------------------------------------------------------------------------
  logic btn_prev_q, btn_pulse_q;
  logic mode_prev_q, mode_chg;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      btn_prev_q  <= 1'b0;
      btn_pulse_q <= 1'b0;
      mode_prev_q <= 1'b0;
    end else begin
      btn_prev_q  <= deb_q[2];
      btn_pulse_q <= deb_q[2] & ~btn_prev_q;
      mode_prev_q <= mode_s;
    end
  end

  assign mode_chg = mode_s ^ mode_prev_q;

  // ---------------------------------------------------------------------------
  // Auto-mode divider
  // ---------------------------------------------------------------------------
  logic [DivW-1:0] div_q, div_d;
  logic            tick;

  always_comb begin
    if (!mode_s || mode_chg || (div_q == DivLast)) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = mode_s & (div_q == DivLast);

  // ---------------------------------------------------------------------------
  // Step FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic       trigger;
  logic       j_q, j_d, k_q, k_d;
  logic       step_auto_q, step_auto_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] step_cnt_q, step_cnt_d;
  logic       ff_clk_q, ff_clk_d;
  logic       busy_q, busy_d;
  logic       phase_j, phase_k;

  assign trigger = mode_s ? tick : btn_pulse_q;
  assign phase_j = ~phase_q[1];
  assign phase_k = phase_q[1] ^ phase_q[0];

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    k_d         = k_q;
    step_auto_d = step_auto_q;
    phase_d     = phase_q;
    step_cnt_d  = step_cnt_q;

    unique case (state_q)
      StIdle: begin
        // Triggers outside IDLE are simply ignored, so no queuing exists
        if (trigger) begin
          state_d     = StSetup;
          step_auto_d = mode_s;
          j_d         = mode_s ? phase_j : deb_q[0];
          k_d         = mode_s ? phase_k : deb_q[1];
        end
      end
      StSetup: begin
        state_d    = StHigh1;
        step_cnt_d = step_cnt_q + 8'd1;
        if (step_auto_q) begin
          phase_d = phase_q + 2'd1;
        end
      end
      StHigh1: state_d = StHigh2;
      StHigh2: state_d = StHold;
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A mode change restarts the auto pattern; the in-flight step is untouched
    if (mode_chg) begin
      phase_d = PhaseSet;
    end
  end

  // Registered outputs keep FF_CLK free of decode glitches
  assign ff_clk_d = (state_d == StHigh1) || (state_d == StHigh2);
  assign busy_d   = (state_d != StIdle);

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q     <= StIdle;
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      step_auto_q <= 1'b0;
      phase_q     <= PhaseSet;
      step_cnt_q  <= '0;
      ff_clk_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      k_q         <= k_d;
      step_auto_q <= step_auto_d;
      phase_q     <= phase_d;
      step_cnt_q  <= step_cnt_d;
      ff_clk_q    <= ff_clk_d;
      busy_q      <= busy_d;
    end
  end

  assign J_OUT    = j_q;
  assign K_OUT    = k_q;
  assign FF_CLK   = ff_clk_q;
  assign BUSY     = busy_q;
  assign STEP_CNT = step_cnt_q;

endmodule

// File: tb/tb_jk_step_driver.sv
// Testbench for jk_step_driver. Expected pulses (J/K before the rise, STEP_CNT
// after it, spacing to the previous pulse) are queued as stimulus is applied
// and consumed when FF_CLK rises. A second instance with DB_CYCLES = 2 is used
// where a re-press has to land inside the 4-cycle busy window.
module tb_jk_step_driver;

  localparam int unsigned DbCycles = 4;
  localparam int unsigned Div      = 8;

  logic       CLK      = 1'b0;
  logic       RST_n    = 1'b0;
  logic       SW_J     = 1'b0;
  logic       SW_K     = 1'b0;
  logic       BTN_STEP = 1'b0;
  logic       MODE     = 1'b0;
  logic       J_OUT, K_OUT, FF_CLK, BUSY;
  logic [7:0] STEP_CNT;

  logic       fast_j, fast_k, fast_ff, fast_busy;
  logic [7:0] fast_cnt;

  jk_step_driver #(
    .DB_CYCLES(DbCycles),
    .DIV      (Div)
  ) u_dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .SW_J    (SW_J),
    .SW_K    (SW_K),
    .BTN_STEP(BTN_STEP),
    .MODE    (MODE),
    .J_OUT   (J_OUT),
    .K_OUT   (K_OUT),
    .FF_CLK  (FF_CLK),
    .BUSY    (BUSY),
    .STEP_CNT(STEP_CNT)
  );

  jk_step_driver #(
    .DB_CYCLES(2),
    .DIV      (Div)
  ) u_fast (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .SW_J    (SW_J),
    .SW_K    (SW_K),
    .BTN_STEP(BTN_STEP),
    .MODE    (MODE),
    .J_OUT   (fast_j),
    .K_OUT   (fast_k),
    .FF_CLK  (fast_ff),
    .BUSY    (fast_busy),
    .STEP_CNT(fast_cnt)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Scoreboard of expected pulses
  typedef struct {
    int j;
    int k;
    int cnt;
    int gap;  // 0 = spacing not checked
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input int j, input int k, input int cnt, input int gap);
    exp_t e;
    e.j   = j;
    e.k   = k;
    e.cnt = cnt & 255;
    e.gap = gap;
    sb.push_back(e);
  endtask

  // Pulse monitor, sampled on the falling edge
  logic mon_ff    = 1'b0;
  logic mon_j     = 1'b0;
  logic mon_k     = 1'b0;
  int   hold_j    = 0;
  int   hold_k    = 0;
  int   hi_len    = 0;
  int   busy_len  = 0;
  int   last_rise = 0;
  exp_t mon_e;

  always @(negedge CLK) begin
    if (!RST_n) begin
      mon_ff   = 1'b0;
      hi_len   = 0;
      busy_len = 0;
    end else begin
      if (FF_CLK && !mon_ff) begin
        chk("pulse_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("j_before_rise", mon_j, mon_e.j);
          chk("k_before_rise", mon_k, mon_e.k);
          chk("step_cnt", STEP_CNT, mon_e.cnt);
          if (mon_e.gap != 0) chk("pulse_gap", cyc - last_rise, mon_e.gap);
          hold_j = mon_e.j;
          hold_k = mon_e.k;
        end
        last_rise = cyc;
        hi_len    = 0;
      end
      if (FF_CLK) hi_len++;
      if (!FF_CLK && mon_ff) begin
        chk("ff_high_cycles", hi_len, 2);
        chk("j_after_fall", J_OUT, hold_j);
        chk("k_after_fall", K_OUT, hold_k);
      end
      if (BUSY) begin
        busy_len++;
      end else if (busy_len != 0) begin
        chk("busy_cycles", busy_len, 4);
        busy_len = 0;
      end
      mon_ff = FF_CLK;
    end
    mon_j = J_OUT;
    mon_k = K_OUT;
  end

  // Rise counter for the fast instance
  logic fast_ff_q  = 1'b0;
  int   fast_rises = 0;
  always @(negedge CLK) begin
    if (fast_ff && !fast_ff_q) fast_rises++;
    fast_ff_q = fast_ff;
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_n    = 1'b0;
    SW_J     = 1'b0;
    SW_K     = 1'b0;
    BTN_STEP = 1'b0;
    MODE     = 1'b0;
    step(3);
    RST_n = 1'b1;
    step(2);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i;
    i = 0;
    while (sb.size() != 0 && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  int         press_cyc;
  int         fast_rises0;
  logic [7:0] fast_cnt0;
  logic [7:0] fast_delta;

  initial begin
    step(1);

    // Reset with every input high
    RST_n    = 1'b0;
    SW_J     = 1'b1;
    SW_K     = 1'b1;
    BTN_STEP = 1'b1;
    MODE     = 1'b1;
    step(3);
    chk("rst_j", J_OUT, 0);
    chk("rst_k", K_OUT, 0);
    chk("rst_ff", FF_CLK, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cnt", STEP_CNT, 0);
    RST_n = 1'b1;
    for (int i = 0; i < int'(DbCycles) + 3; i++) begin
      step(1);
      chk("no_early_pulse", FF_CLK, 0);
    end

    // Manual set: short bounce rejected, held press gives one step
    do_reset();
    SW_J = 1'b1;
    SW_K = 1'b0;
    step(10);
    push_exp(1, 0, 1, 0);
    BTN_STEP = 1'b1;
    step(2);
    BTN_STEP = 1'b0;
    step(5);
    press_cyc = cyc;
    BTN_STEP  = 1'b1;
    step(20);
    BTN_STEP = 1'b0;
    step(20);
    chk("manual_drained", sb.size(), 0);
    chk("manual_latency", last_rise - press_cyc, int'(DbCycles) + 5);
    chk("manual_cnt", STEP_CNT, 1);
    sb.delete();

    // Auto pattern
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_exp(int'((i % 4) < 2), int'((i % 4) == 1 || (i % 4) == 2), i + 1, (i == 0) ? 0 : 8);
    end
    MODE = 1'b1;
    wait_drain("auto_drained", 200);
    MODE = 1'b0;
    step(10);

    // Mode switch during HIGH
    push_exp(1, 0, 9, 0);
    push_exp(1, 1, 10, 8);
    MODE = 1'b1;
    wait_drain("modesw_drained", 100);
    chk("modesw_in_high", FF_CLK, 1);
    MODE = 1'b0;
    step(30);
    push_exp(1, 0, 11, 0);
    MODE = 1'b1;
    wait_drain("modesw_reentry", 100);
    MODE = 1'b0;
    step(10);

    // Busy drop: second press lands while the first step is still running
    SW_J = 1'b0;
    SW_K = 1'b1;
    step(10);
    fast_cnt0   = fast_cnt;
    fast_rises0 = fast_rises;
    push_exp(0, 1, 12, 0);
    BTN_STEP = 1'b1;
    step(2);
    BTN_STEP = 1'b0;
    step(2);
    BTN_STEP = 1'b1;
    step(20);
    BTN_STEP = 1'b0;
    step(20);
    fast_delta = fast_cnt - fast_cnt0;
    chk("busydrop_rises", fast_rises - fast_rises0, 1);
    chk("busydrop_cnt", fast_delta, 1);
    chk("busydrop_main", sb.size(), 0);
    sb.delete();

    // Wrap over 256 steps, then reset in the middle of a pulse
    do_reset();
    for (int i = 0; i < 257; i++) begin
      push_exp(int'((i % 4) < 2), int'((i % 4) == 1 || (i % 4) == 2), i + 1, (i == 0) ? 0 : 8);
    end
    MODE = 1'b1;
    wait_drain("wrap_drained", 3000);
    chk("wrap_in_high", FF_CLK, 1);
    RST_n = 1'b0;
    step(1);
    chk("abort_ff", FF_CLK, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_cnt", STEP_CNT, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
